// File: rtl/vga_timing_pkg.sv
// Nominal VGA timing shared by the sync generator and the sync receiver, plus the
// receiver lock-state encoding and a tolerance helper.
package vga_timing_pkg;

  localparam int unsigned VgaCntW       = 11;
  localparam int unsigned VgaHTotal     = 1600;
  localparam int unsigned VgaHSync      = 192;
  localparam int unsigned VgaHActStart  = 290;
  localparam int unsigned VgaHActClks   = 1278;
  localparam int unsigned VgaClkPerPix  = 2;
  localparam int unsigned VgaVActStart  = 35;
  localparam int unsigned VgaVActLines  = 480;
  localparam int unsigned VgaTol        = 4;
  localparam int unsigned VgaLockLines  = 4;
  localparam int unsigned VgaLossLines  = 3;

  typedef enum logic [1:0] {
    StSearch,
    StAcquire,
    StLocked
  } rx_state_e;

  // Unsigned |val - nom| <= tol, written so nothing can wrap below zero.
  function automatic logic within_tol(input int unsigned val, input int unsigned nom,
                                      input int unsigned tol);
    return ((val + tol) >= nom) && (val <= (nom + tol));
  endfunction

endpackage

// File: rtl/vga_sync_receiver_if.sv
// Raw sync inputs and recovered timing outputs of the VGA sync receiver.
// master = timing source / monitor side, slave = receiver.
interface vga_sync_receiver_if
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W = VgaCntW
);
  logic             hsync_in;
  logic             vsync_in;
  logic             locked;
  logic             pix_valid;
  logic [9:0]       pix_x;
  logic [9:0]       pix_y;
  logic [CNT_W-1:0] line_period;
  logic [CNT_W-1:0] sync_width;
  logic             line_err;
  logic             frame_start;

  modport master (
    output hsync_in, vsync_in,
    input  locked, pix_valid, pix_x, pix_y, line_period, sync_width, line_err, frame_start
  );

  modport slave (
    input  hsync_in, vsync_in,
    output locked, pix_valid, pix_x, pix_y, line_period, sync_width, line_err, frame_start
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous active-low sync pin, followed by a
// registered edge detector; level_o, fall_o and rise_o are mutually aligned.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  // [0],[1] form the synchronizer; [2] is the delayed copy used for edge detection.
  logic [2:0] sync_q;
  logic       fall_q;
  logic       rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
      fall_q <= sync_q[2] & ~sync_q[1];
      rise_q <= ~sync_q[2] & sync_q[1];
    end
  end

  assign level_o = sync_q[2];
  assign fall_o  = fall_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// Measures incoming hsync period/width, locks onto nominal VGA timing and
// regenerates pixel coordinates and the display-area flag.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W       = VgaCntW,
  parameter int unsigned H_TOTAL     = VgaHTotal,
  parameter int unsigned H_SYNC      = VgaHSync,
  parameter int unsigned H_ACT_START = VgaHActStart,
  parameter int unsigned H_ACT_CLKS  = VgaHActClks,
  parameter int unsigned CLK_PER_PIX = VgaClkPerPix,
  parameter int unsigned V_ACT_START = VgaVActStart,
  parameter int unsigned V_ACT_LINES = VgaVActLines,
  parameter int unsigned TOL         = VgaTol,
  parameter int unsigned LOCK_LINES  = VgaLockLines,
  parameter int unsigned LOSS_LINES  = VgaLossLines
) (
  input logic               clk,
  input logic               rst,
  vga_sync_receiver_if.slave vga_io
);

  localparam int unsigned     RunW     = 8;
  localparam int unsigned     PixShift = $clog2(CLK_PER_PIX);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [9:0]      VLineMax = '1;

  logic hlevel, hfall, hrise;
  logic vlevel, vfall, vrise;

  sync_edge_detect u_hsync (
    .clk    (clk),
    .rst    (rst),
    .async_i(vga_io.hsync_in),
    .level_o(hlevel),
    .fall_o (hfall),
    .rise_o (hrise)
  );

  sync_edge_detect u_vsync (
    .clk    (clk),
    .rst    (rst),
    .async_i(vga_io.vsync_in),
    .level_o(vlevel),
    .fall_o (vfall),
    .rise_o (vrise)
  );

  logic unused_vsync;
  assign unused_vsync = vlevel ^ vrise;

  logic [CNT_W-1:0] cnt_q, cnt_d, wcnt_q, wcnt_d;
  logic [CNT_W-1:0] line_period_q, line_period_d, sync_width_q, sync_width_d;
  logic [9:0]       vline_q, vline_d;
  logic             pix_valid_q, pix_valid_d;
  logic [9:0]       pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [CNT_W:0]   period_now;
  logic [CNT_W-1:0] h_off;
  logic             cnt_sat, line_good, h_act, v_act;

  rx_state_e        state_q;
  logic [RunW-1:0]  good_q, bad_q;
  logic             locked_q, line_err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (hfall) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    wcnt_d = wcnt_q;
    if (hfall) begin
      wcnt_d = '0;
    end else if (!hlevel && (wcnt_q != CntMax)) begin
      wcnt_d = wcnt_q + CNT_W'(1);
    end

    // Period ending at this hfall; a saturated counter reports the ceiling.
    period_now    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    line_period_d = line_period_q;
    if (hfall) begin
      line_period_d = (cnt_q == CntMax) ? CntMax : period_now[CNT_W-1:0];
    end

    // wcnt misses the first low cycle (it is cleared on hfall), hence the +1.
    sync_width_d = sync_width_q;
    if (hrise) begin
      sync_width_d = (wcnt_q == CntMax) ? CntMax : wcnt_q + CNT_W'(1);
    end

    vline_d = vline_q;
    if (vfall) begin
      vline_d = '0;
    end else if (hfall && (vline_q != VLineMax)) begin
      vline_d = vline_q + 10'd1;
    end

    cnt_sat   = !hfall && (cnt_d == CntMax);
    line_good = within_tol(32'(period_now), H_TOTAL, TOL) &&
                within_tol(32'(sync_width_q), H_SYNC, TOL);

    h_act = (cnt_q >= CNT_W'(H_ACT_START)) && (cnt_q < CNT_W'(H_ACT_START + H_ACT_CLKS));
    v_act = (vline_q >= 10'(V_ACT_START)) && (vline_q < 10'(V_ACT_START + V_ACT_LINES));
    h_off = cnt_q - CNT_W'(H_ACT_START);

    pix_valid_d = locked_q && h_act && v_act;
    pix_x_d     = pix_valid_d ? 10'(h_off >> PixShift) : 10'd0;
    pix_y_d     = pix_valid_d ? (vline_q - 10'(V_ACT_START)) : 10'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      wcnt_q        <= '0;
      line_period_q <= '0;
      sync_width_q  <= '0;
      vline_q       <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
    end else begin
      cnt_q         <= cnt_d;
      wcnt_q        <= wcnt_d;
      line_period_q <= line_period_d;
      sync_width_q  <= sync_width_d;
      vline_q       <= vline_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
    end
  end

  // Lock FSM: judged once per hfall, except a stalled line counter which
  // drops to search immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StSearch;
      good_q     <= '0;
      bad_q      <= '0;
      locked_q   <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      line_err_q <= 1'b0;
      if (cnt_sat) begin
        state_q  <= StSearch;
        locked_q <= 1'b0;
      end else if (hfall) begin
        case (state_q)
          StSearch: begin
            state_q <= StAcquire;
            good_q  <= '0;
          end
          StAcquire: begin
            if (!line_good) begin
              good_q <= '0;
            end else if ((good_q + RunW'(1)) == RunW'(LOCK_LINES)) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
              good_q   <= good_q + RunW'(1);
              bad_q    <= '0;
            end else begin
              good_q <= good_q + RunW'(1);
            end
          end
          StLocked: begin
            if (line_good) begin
              bad_q <= '0;
            end else begin
              line_err_q <= 1'b1;
              bad_q      <= bad_q + RunW'(1);
              if ((bad_q + RunW'(1)) == RunW'(LOSS_LINES)) begin
                state_q  <= StSearch;
                locked_q <= 1'b0;
              end
            end
          end
          default: begin
            state_q  <= StSearch;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign vga_io.locked      = locked_q;
  assign vga_io.pix_valid   = pix_valid_q;
  assign vga_io.pix_x       = pix_x_q;
  assign vga_io.pix_y       = pix_y_q;
  assign vga_io.line_period = line_period_q;
  assign vga_io.sync_width  = sync_width_q;
  assign vga_io.line_err    = line_err_q;
  assign vga_io.frame_start = vfall;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver: line-level timing model feeding a
// scoreboard that is drained a fixed latency after each hsync fall.
module tb_vga_sync_receiver;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vga_sync_receiver_if #(.CNT_W(11)) vga_if ();

  vga_sync_receiver dut (
    .clk   (clk),
    .rst   (rst),
    .vga_io(vga_if)
  );

  typedef struct {
    bit chk_period;
    int period;
    bit chk_width;
    int width;
    bit locked;
    int errs;
    int frames;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int fs_seen  = 0;

  // Model state: 0 search, 1 acquire, 2 locked.
  int m_state = 0, m_good = 0, m_bad = 0, m_errs = 0, m_frames = 0, m_vline = 0;
  bit have_prev = 1'b0, prev_sat = 1'b0;
  int prev_period = 0, prev_width = 0;

  always @(negedge clk) begin
    if (vga_if.line_err === 1'b1) err_seen++;
    if (vga_if.frame_start === 1'b1) fs_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit in_tol(input int v, input int nom, input int tol);
    return (v >= nom - tol) && (v <= nom + tol);
  endfunction

  task automatic check_reset(input string tag);
    check_eq({tag, "_locked"}, vga_if.locked, 0);
    check_eq({tag, "_pix_valid"}, vga_if.pix_valid, 0);
    check_eq({tag, "_pix_x"}, vga_if.pix_x, 0);
    check_eq({tag, "_pix_y"}, vga_if.pix_y, 0);
    check_eq({tag, "_line_period"}, vga_if.line_period, 0);
    check_eq({tag, "_sync_width"}, vga_if.sync_width, 0);
    check_eq({tag, "_line_err"}, vga_if.line_err, 0);
    check_eq({tag, "_frame_start"}, vga_if.frame_start, 0);
  endtask

  // Model reaction to an hsync fall, which closes the previous line.
  task automatic model_fall(input bit vs, output exp_t e);
    bit good;
    good = have_prev && !prev_sat && in_tol(prev_period, 1600, 4) && in_tol(prev_width, 192, 4);
    case (m_state)
      0: begin
        m_state = 1;
        m_good  = 0;
      end
      1: begin
        if (good) begin
          m_good++;
          if (m_good == 4) begin
            m_state = 2;
            m_bad   = 0;
          end
        end else begin
          m_good = 0;
        end
      end
      default: begin
        if (good) begin
          m_bad = 0;
        end else begin
          m_bad++;
          m_errs++;
          if (m_bad == 3) m_state = 0;
        end
      end
    endcase
    if (vs) begin
      m_vline = 0;
      m_frames++;
    end else if (m_vline < 1023) begin
      m_vline++;
    end
    e.chk_period = have_prev && !prev_sat;
    e.period     = prev_period;
    e.chk_width  = have_prev;
    e.width      = prev_width;
    e.locked     = (m_state == 2);
    e.errs       = m_errs;
    e.frames     = m_frames;
  endtask

  task automatic compare_pop();
    exp_t e;
    e = sb_q.pop_front();
    if (e.chk_period) check_eq("line_period", vga_if.line_period, e.period);
    if (e.chk_width) check_eq("sync_width", vga_if.sync_width, e.width);
    check_eq("locked", vga_if.locked, e.locked);
    check_eq("line_err_count", err_seen, e.errs);
    check_eq("frame_start_count", fs_seen, e.frames);
  endtask

  // One line starting with an hsync fall; rst_at > 0 pulses rst at that cycle.
  task automatic send_line(input int period, input int width, input bit vs, input int rst_at);
    exp_t e;
    bit   act;
    int   y_exp;
    model_fall(vs, e);
    sb_q.push_back(e);
    act   = (m_state == 2) && (m_vline >= 35) && (m_vline < 515);
    y_exp = act ? (m_vline - 35) : 0;
    for (int c = 0; c < period; c++) begin
      vga_if.hsync_in = (c < width) ? 1'b0 : 1'b1;
      if (vs) vga_if.vsync_in = (c < width) ? 1'b0 : 1'b1;
      if (rst_at > 0 && c == rst_at) rst = 1'b1;
      @(negedge clk);
      if (c == 5) compare_pop();
      if (rst_at == 0 || c < rst_at) begin
        if (c == 294) check_eq("pix_valid_before_window", vga_if.pix_valid, 0);
        if (c == 295) begin
          check_eq("pix_valid_first", vga_if.pix_valid, act);
          check_eq("pix_x_first", vga_if.pix_x, 0);
          check_eq("pix_y", vga_if.pix_y, y_exp);
        end
        if (c == 1572) begin
          check_eq("pix_valid_last", vga_if.pix_valid, act);
          check_eq("pix_x_last", vga_if.pix_x, act ? 638 : 0);
        end
        if (c == 1573) check_eq("pix_valid_after_window", vga_if.pix_valid, 0);
      end
      if (rst_at > 0 && c == rst_at) check_reset("mid_line_rst");
      @(posedge clk);
      #1;
      if (rst_at > 0 && c == rst_at) rst = 1'b0;
    end
    if (rst_at > 0) begin
      m_state   = 0;
      m_good    = 0;
      m_bad     = 0;
      m_vline   = 0;
      have_prev = 1'b0;
      prev_sat  = 1'b0;
    end else begin
      have_prev   = 1'b1;
      prev_sat    = 1'b0;
      prev_period = period;
      prev_width  = width;
    end
  endtask

  // Hold hsync high so the line counter saturates.
  task automatic stall(input int cycles);
    bit was_locked;
    int off;
    was_locked = (m_state == 2);
    for (int k = 0; k < cycles; k++) begin
      vga_if.hsync_in = 1'b1;
      @(negedge clk);
      off = prev_period + k;
      if (off == 2050) check_eq("locked_before_saturate", vga_if.locked, was_locked);
      if (off == 2051) check_eq("locked_after_saturate", vga_if.locked, 0);
      @(posedge clk);
      #1;
    end
    m_state  = 0;
    prev_sat = 1'b1;
  endtask

  initial begin
    vga_if.hsync_in = 1'b1;
    vga_if.vsync_in = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    // Nominal lines, vsync coincident with the first hsync fall.
    send_line(1600, 192, 1'b1, 0);
    repeat (5) send_line(1600, 192, 1'b0, 0);

    // Tolerance boundaries while locked, then three bad lines.
    send_line(1604, 192, 1'b0, 0);
    send_line(1605, 192, 1'b0, 0);
    send_line(1600, 192, 1'b0, 0);
    send_line(1600, 196, 1'b0, 0);
    send_line(1600, 197, 1'b0, 0);
    send_line(1596, 192, 1'b0, 0);
    repeat (3) send_line(1610, 192, 1'b0, 0);

    // Re-lock, then stop hsync until the counter saturates.
    repeat (6) send_line(1600, 192, 1'b0, 0);
    stall(700);

    // Restart; lock returns and the active window is reached at line 35.
    repeat (15) send_line(1600, 192, 1'b0, 0);
    send_line(1600, 192, 1'b0, 800);
    repeat (5) send_line(1600, 192, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
